// File: rtl/decode_issue_queue_if.sv
// Fetch-side, execute-side and writeback signals of the decode/issue queue.
// master = surrounding pipeline / bench, slave = the queue itself.
interface decode_issue_queue_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64,
    parameter int NREG  = 32
) ();
    localparam int CW = $clog2(DEPTH + 1);

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [2:0]      out_fmt;
    logic [XLEN-1:0] out_imm;
    logic            out_wen;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [NREG-1:0] busy_vec;
    logic [CW-1:0]   count;

    modport master (
        output flush, in_valid, in_pc, in_instr, out_ready, wb_valid, wb_rd,
        input  in_ready, out_valid, out_pc, out_instr, out_rs1, out_rs2, out_rd,
        input  out_fmt, out_imm, out_wen, busy_vec, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_instr, out_ready, wb_valid, wb_rd,
        output in_ready, out_valid, out_pc, out_instr, out_rs1, out_rs2, out_rd,
        output out_fmt, out_imm, out_wen, busy_vec, count
    );
endinterface

// File: rtl/decode_issue_queue.sv
// Circular instruction queue between fetch and execute: decodes the head entry and
// holds issue back while a source register still has an in-flight writer.
module decode_issue_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64,
    parameter int NREG  = 32
) (
    input logic                 clk,
    input logic                 resetn,
    decode_issue_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;
    localparam logic [2:0] FMT_C = 3'd6;
    localparam logic [2:0] FMT_Z = 3'd7;

    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [XLEN-1:0] pc_d    [DEPTH];
    logic [31:0]     instr_q [DEPTH];
    logic [31:0]     instr_d [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [NREG-1:0] busy_q, busy_d;

    logic [31:0]     hi;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
    logic            use_rs1, use_rs2, wen, stall;
    logic            busy_rs1, busy_rs2;
    logic            in_ready_w, out_valid_w, enq, issue;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Register indices are 5 bits; anything at or above NREG is simply never busy.
    function automatic logic busy_at(input logic [NREG-1:0] v, input logic [4:0] idx);
        logic hit;
        hit = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            if (idx == 5'(r)) hit = v[r];
        end
        return hit;
    endfunction

    assign hi     = instr_q[head_q];
    assign opcode = hi[6:0];
    assign funct3 = hi[14:12];

    always_comb begin
        fmt = FMT_R;
        case (opcode)
            7'b0110111, 7'b0010111: fmt = FMT_U;
            7'b1101111:             fmt = FMT_J;
            7'b1100111, 7'b0000011,
            7'b0010011, 7'b0011011: fmt = FMT_I;
            7'b0100011:             fmt = FMT_S;
            7'b1100011:             fmt = FMT_B;
            7'b1110011: begin
                case (funct3)
                    3'd0:             fmt = FMT_I;
                    3'd1, 3'd2, 3'd3: fmt = FMT_C;
                    3'd5, 3'd6, 3'd7: fmt = FMT_Z;
                    default:          fmt = FMT_R;
                endcase
            end
            default: fmt = FMT_R;
        endcase
    end

    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I: imm = XLEN'($signed(hi[31:20]));
            FMT_S: imm = XLEN'($signed({hi[31:25], hi[11:7]}));
            FMT_B: imm = XLEN'($signed({hi[31], hi[7], hi[30:25], hi[11:8], 1'b0}));
            FMT_U: imm = XLEN'($signed({hi[31:12], 12'b0}));
            FMT_J: imm = XLEN'($signed({hi[31], hi[19:12], hi[20], hi[30:21], 1'b0}));
            FMT_C: imm = XLEN'(hi[31:20]);
            FMT_Z: imm = XLEN'(hi[19:15]);
            default: imm = '0;
        endcase
    end

    assign use_rs1  = (fmt != FMT_U) && (fmt != FMT_J) && (fmt != FMT_Z);
    assign use_rs2  = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
    assign wen      = (hi[11:7] != 5'd0) && (fmt != FMT_S) && (fmt != FMT_B);
    assign busy_rs1 = busy_at(busy_q, hi[19:15]);
    assign busy_rs2 = busy_at(busy_q, hi[24:20]);
    assign stall    = (use_rs1 && busy_rs1) || (use_rs2 && busy_rs2);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
    // in_ready looks only at registered occupancy; out_valid never waits on out_ready.
    assign in_ready_w  = resetn && (count_q != CW'(DEPTH));
    assign out_valid_w = resetn && (count_q != '0) && !stall && !bus.flush;
    assign enq         = bus.in_valid && in_ready_w && !bus.flush;
    assign issue       = out_valid_w && bus.out_ready;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq) begin
            pc_d[tail_q]    = bus.in_pc;
            instr_d[tail_q] = bus.in_instr;
        end
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq)   tail_d = ptr_inc(tail_q);
            if (issue) head_d = ptr_inc(head_q);
            if (enq && !issue)      count_d = count_q + 1'b1;
            else if (!enq && issue) count_d = count_q - 1'b1;
        end
    end

    // Clear first so that an issuing writer re-marks the same register busy.
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NREG; r++) begin
            if (bus.wb_valid && (bus.wb_rd == 5'(r))) busy_d[r] = 1'b0;
            if (issue && wen && (hi[11:7] == 5'(r)))  busy_d[r] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            busy_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        pc_q    <= pc_d;
        instr_q <= instr_d;
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_pc    = pc_q[head_q];
    assign bus.out_instr = hi;
    assign bus.out_rs1   = hi[19:15];
    assign bus.out_rs2   = hi[24:20];
    assign bus.out_rd    = hi[11:7];
    assign bus.out_fmt   = fmt;
    assign bus.out_imm   = imm;
    assign bus.out_wen   = wen;
    assign bus.busy_vec  = busy_q;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_decode_issue_queue.sv
// Directed scenarios plus randomized traffic against a queue-based reference model;
// a second DEPTH=3 instance exercises pointer wrap.
module tb_decode_issue_queue;
    localparam int D  = 4;
    localparam int D3 = 3;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic clk = 1'b0;
    logic resetn;
    int   n_total = 0;
    int   n_bad   = 0;

    ent_t        mq[$];
    bit   [31:0] mbusy;
    logic [95:0] exp_q[$];

    always #5 clk = ~clk;

    decode_issue_queue_if #(.DEPTH(D),  .XLEN(64), .NREG(32)) b ();
    decode_issue_queue_if #(.DEPTH(D3), .XLEN(64), .NREG(32)) c ();

    decode_issue_queue #(.DEPTH(D),  .XLEN(64), .NREG(32)) u_dut  (.clk(clk), .resetn(resetn), .bus(b));
    decode_issue_queue #(.DEPTH(D3), .XLEN(64), .NREG(32)) u_dut3 (.clk(clk), .resetn(resetn), .bus(c));

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_b();
        b.flush = 0; b.in_valid = 0; b.in_pc = '0; b.in_instr = '0;
        b.out_ready = 0; b.wb_valid = 0; b.wb_rd = '0;
    endtask

    task automatic idle_c();
        c.flush = 0; c.in_valid = 0; c.in_pc = '0; c.in_instr = '0;
        c.out_ready = 0; c.wb_valid = 0; c.wb_rd = '0;
    endtask

    // Reference decode: fmt codes 0=R 1=I 2=S 3=B 4=U 5=J 6=C 7=Z, immediates via shifts.
    function automatic void ref_decode(input logic [31:0] i, output int fmt, output logic [63:0] imm);
        longint x;
        x = longint'($signed(i));
        case (i[6:0])
            7'h37, 7'h17:               fmt = 4;
            7'h6f:                      fmt = 5;
            7'h67, 7'h03, 7'h13, 7'h1b: fmt = 1;
            7'h23:                      fmt = 2;
            7'h63:                      fmt = 3;
            7'h73: fmt = (i[14:12] == 0) ? 1 : (i[14:12] <= 3) ? 6 : (i[14:12] >= 5) ? 7 : 0;
            default:                    fmt = 0;
        endcase
        case (fmt)
            1: imm = x >>> 20;
            2: imm = ((x >>> 25) << 5) | longint'(i[11:7]);
            3: imm = ((x >>> 31) << 12) | (longint'(i[7]) << 11) | (longint'(i[30:25]) << 5)
                     | (longint'(i[11:8]) << 1);
            4: imm = (x >>> 12) << 12;
            5: imm = ((x >>> 31) << 20) | (longint'(i[19:12]) << 12) | (longint'(i[20]) << 11)
                     | (longint'(i[30:21]) << 1);
            6: imm = longint'(i[31:20]);
            7: imm = longint'(i[19:15]);
            default: imm = '0;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] i;
        i = $urandom;
        case ($urandom_range(0, 11))
            0: i[6:0] = 7'h37;  1: i[6:0] = 7'h17;  2: i[6:0] = 7'h6f;  3: i[6:0] = 7'h67;
            4: i[6:0] = 7'h03;  5: i[6:0] = 7'h13;  6: i[6:0] = 7'h1b;  7: i[6:0] = 7'h23;
            8: i[6:0] = 7'h63;  9: i[6:0] = 7'h73; 10: i[6:0] = 7'h33; default: i[6:0] = 7'h0f;
        endcase
        i[11:7]  = 5'($urandom_range(0, 7));
        i[19:15] = 5'($urandom_range(0, 7));
        i[24:20] = 5'($urandom_range(0, 7));
        if (i[6:0] == 7'h73 && i[14:12] == 3'd4) i[14:12] = 3'd6;
        return i;
    endfunction

    task automatic random_phase(input int ncyc);
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            logic        exp_rdy, exp_vld, enq, deq, stall, u1, u2, wen;
            int          fmt;
            logic [63:0] imm;
            logic [31:0] hi;
            hi = '0; wen = 0; exp_vld = 0;
            b.flush     = ($urandom_range(0, 39) == 0);
            b.in_valid  = ($urandom_range(0, 2) != 0);
            b.in_pc     = {$urandom, $urandom};
            b.in_instr  = rand_instr();
            b.out_ready = ($urandom_range(0, 3) != 0);
            b.wb_valid  = ($urandom_range(0, 2) == 0);
            b.wb_rd     = 5'($urandom_range(0, 7));
            #1;
            exp_rdy = (mq.size() < D);
            check("rnd_in_ready", b.in_ready, exp_rdy);
            check("rnd_count", b.count, mq.size());
            check("rnd_busy", b.busy_vec, mbusy);
            if (mq.size() != 0) begin
                hi = mq[0].instr;
                ref_decode(hi, fmt, imm);
                u1    = !(fmt == 4 || fmt == 5 || fmt == 7);
                u2    = (fmt == 0 || fmt == 2 || fmt == 3);
                wen   = (hi[11:7] != 0) && fmt != 2 && fmt != 3;
                stall = (u1 && mbusy[hi[19:15]]) || (u2 && mbusy[hi[24:20]]);
                exp_vld = !stall && !b.flush;
                check("rnd_pc", b.out_pc, mq[0].pc);
                check("rnd_instr", b.out_instr, hi);
                check("rnd_fmt", b.out_fmt, fmt);
                check("rnd_imm", b.out_imm, imm);
                check("rnd_wen", b.out_wen, wen);
                check("rnd_rs1", b.out_rs1, hi[19:15]);
                check("rnd_rs2", b.out_rs2, hi[24:20]);
                check("rnd_rd", b.out_rd, hi[11:7]);
            end
            check("rnd_out_valid", b.out_valid, exp_vld);
            enq = b.in_valid && exp_rdy && !b.flush;
            deq = exp_vld && b.out_ready;
            if (b.wb_valid && b.wb_rd != 0) mbusy[b.wb_rd] = 1'b0;
            if (deq && wen) mbusy[hi[11:7]] = 1'b1;
            if (b.flush) mq.delete();
            else begin
                if (deq) void'(mq.pop_front());
                if (enq) mq.push_back('{pc: b.in_pc, instr: b.in_instr});
            end
            step();
        end
        idle_b();
    endtask

    function automatic logic [31:0] rand_nowrite();
        logic [31:0] i;
        i = $urandom;
        i[6:0] = ($urandom_range(0, 1) != 0) ? 7'h23 : 7'h63;
        return i;
    endfunction

    task automatic wrap_test();
        logic [95:0] e;
        for (int k = 0; k < 2; k++) begin
            c.in_valid = 1; c.in_pc = 64'h4000 + 64'(k * 4); c.in_instr = rand_nowrite();
            exp_q.push_back({c.in_pc, c.in_instr});
            step();
        end
        for (int k = 2; k < 12; k++) begin
            c.in_valid = 1; c.in_pc = 64'h4000 + 64'(k * 4); c.in_instr = rand_nowrite();
            c.out_ready = 1;
            #1;
            check("wrap_valid", c.out_valid, 1'b1);
            e = exp_q.pop_front();
            check("wrap_order", {c.out_pc, c.out_instr}, e);
            exp_q.push_back({c.in_pc, c.in_instr});
            step();
            check("wrap_count", c.count, 2);
        end
        c.in_valid = 0;
        for (int k = 0; k < 2; k++) begin
            #1;
            e = exp_q.pop_front();
            check("wrap_drain", {c.out_pc, c.out_instr}, e);
            step();
        end
        check("wrap_empty", c.count, 0);
        idle_c();
    endtask

    logic [31:0] fill_i [4];

    initial begin
        fill_i[0] = 32'hFE20AE23;  // sw x2,-4(x1)
        fill_i[1] = 32'hFE000CE3;  // beq x0,x0,-8
        fill_i[2] = 32'h300FD3F3;  // csrrwi x7,mstatus,0x1F
        fill_i[3] = 32'h800003B7;  // lui x7,0x80000
        mbusy = '0;
        idle_b(); idle_c();
        resetn = 0;
        repeat (3) step();
        #1;
        check("rst_in_ready", b.in_ready, 0);
        check("rst_out_valid", b.out_valid, 0);
        resetn = 1;
        #1;
        check("rst_count", b.count, 0);
        check("rst_busy", b.busy_vec, 0);
        check("post_rst_in_ready", b.in_ready, 1);

        b.in_valid = 1; b.in_pc = 64'h8000_0000; b.in_instr = 32'hFFF00293;
        #1;
        check("no_passthru", b.out_valid, 0);
        step(); b.in_valid = 0; #1;
        check("addi_valid", b.out_valid, 1);
        check("addi_fmt", b.out_fmt, 1);
        check("addi_imm", b.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        check("addi_rd", b.out_rd, 5);
        check("addi_wen", b.out_wen, 1);
        check("addi_pc", b.out_pc, 64'h8000_0000);

        b.out_ready = 1; b.in_valid = 1; b.in_pc = 64'h8000_0004; b.in_instr = 32'h00528333;
        step(); b.in_valid = 0; #1;
        check("issue_busy5", b.busy_vec, 32'h20);
        check("raw_count", b.count, 1);
        check("raw_stall", b.out_valid, 0);
        check("raw_head", b.out_instr, 32'h00528333);
        step(); #1;
        check("raw_hold", b.out_valid, 0);
        b.wb_valid = 1; b.wb_rd = 5; #1;
        check("wb_no_bypass", b.out_valid, 0);
        step(); b.wb_valid = 0; #1;
        check("wb_clear5", b.busy_vec, 0);
        check("wb_release", b.out_valid, 1);
        step(); b.out_ready = 0; #1;
        check("add_busy6", b.busy_vec, 32'h40);
        check("add_count", b.count, 0);
        b.wb_valid = 1; b.wb_rd = 6; step(); b.wb_valid = 0; #1;
        check("wb_clear6", b.busy_vec, 0);

        for (int k = 0; k < 4; k++) begin
            b.in_valid = 1; b.in_pc = 64'h1000 + 64'(k * 4); b.in_instr = fill_i[k];
            step();
        end
        b.in_valid = 0; #1;
        check("full_count", b.count, 4);
        check("full_in_ready", b.in_ready, 0);
        check("sw_fmt", b.out_fmt, 2);
        check("sw_imm", b.out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        check("sw_wen", b.out_wen, 0);
        b.in_valid = 1; b.in_instr = 32'h00000013; b.out_ready = 1; #1;
        check("full_deq_ready", b.in_ready, 0);
        check("full_deq_valid", b.out_valid, 1);
        step(); b.in_valid = 0; b.out_ready = 0; #1;
        check("full_deq_count", b.count, 3);
        check("beq_fmt", b.out_fmt, 3);
        check("beq_imm", b.out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
        check("beq_pc", b.out_pc, 64'h1004);
        b.out_ready = 1; step(); b.out_ready = 0; #1;
        check("csr_fmt", b.out_fmt, 7);
        check("csr_imm", b.out_imm, 64'h1F);
        check("csr_wen", b.out_wen, 1);
        check("csr_rd", b.out_rd, 7);
        b.out_ready = 1; step(); b.out_ready = 0; #1;
        check("csr_busy7", b.busy_vec, 32'h80);
        check("lui_fmt", b.out_fmt, 4);
        check("lui_imm", b.out_imm, 64'hFFFF_FFFF_8000_0000);
        check("lui_no_waw_stall", b.out_valid, 1);
        b.out_ready = 1; b.wb_valid = 1; b.wb_rd = 7;
        step(); b.out_ready = 0; b.wb_valid = 0; #1;
        check("set_wins", b.busy_vec, 32'h80);
        check("lui_count", b.count, 0);

        for (int k = 0; k < 3; k++) begin
            b.in_valid = 1; b.in_pc = 64'h2000 + 64'(k * 4); b.in_instr = 32'hFE20AE23;
            step();
        end
        b.in_valid = 0; #1;
        check("pre_flush_count", b.count, 3);
        b.flush = 1; b.in_valid = 1; b.out_ready = 1; #1;
        check("flush_no_issue", b.out_valid, 0);
        step(); b.flush = 0; b.in_valid = 0; b.out_ready = 0; #1;
        check("flush_count", b.count, 0);
        check("flush_busy_kept", b.busy_vec, 32'h80);
        check("flush_out_valid", b.out_valid, 0);
        b.wb_valid = 1; b.wb_rd = 7; step(); b.wb_valid = 0; #1;
        check("wb_clear7", b.busy_vec, 0);

        mq.delete();
        mbusy = '0;
        random_phase(3000);
        wrap_test();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
